// File: rtl/dsp_mode_engine.sv
// Four-mode arithmetic engine (add, multiply, dot product, sliding-window correlator)
// with a uniform two-edge latency from accepted beat to Output1/Out_valid.
module dsp_mode_engine #(
    parameter int DW      = 16,
    parameter int DOT_LEN = 3,
    parameter int TAPS    = 9,
    parameter int GUARD   = 6,
    localparam int OW     = 2*DW + GUARD
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    Control,
    input  logic          In_valid,
    input  logic [DW-1:0] Input1,
    input  logic [DW-1:0] Input2,
    output logic [OW-1:0] Output1,
    output logic          Out_valid
);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;
    localparam logic [1:0] MODE_DOT = 2'b10;
    localparam logic [1:0] MODE_WIN = 2'b11;

    localparam int CW = $clog2(DOT_LEN + 1);
    localparam int FW = $clog2(TAPS + 1);

    // Stage 0: accepted beat, mode tracking, counters and the window lines
    logic [1:0]    mode_q;
    logic          beat_valid_reg;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic          emit0_reg;
    logic          dot_start_reg;
    logic [CW-1:0] dot_cnt_reg;
    logic [FW-1:0] fill_reg;
    logic [DW-1:0] sample_line_reg [TAPS];
    logic [DW-1:0] coef_line_reg   [TAPS];

    // Stage 1: sums/products and per-tap window products
    logic          s1_valid_reg;
    logic [1:0]    s1_mode_reg;
    logic [OW-1:0] s1_val_reg;
    logic [OW-1:0] dot_acc_reg;
    logic [2*DW-1:0] win_prod_reg [TAPS];

    logic          mode_switch;
    logic [CW-1:0] cnt_eff;
    logic [FW-1:0] fill_eff;
    logic          dot_last;
    logic          win_full;
    logic [CW-1:0] dot_cnt_next;
    logic [FW-1:0] fill_next;
    logic          emit_next;
    logic          dot_start_next;
    logic          win_shift;

    logic [2*DW-1:0] prod;
    logic [OW-1:0]   dot_acc_sum;
    logic [OW-1:0]   win_sum;

    // A change of mode discards partial DOT/WIN progress before the beat is counted
    always_comb begin
        mode_switch = (Control != mode_q);
        cnt_eff     = mode_switch ? '0 : dot_cnt_reg;
        fill_eff    = mode_switch ? '0 : fill_reg;
        dot_last    = (cnt_eff == CW'(DOT_LEN - 1));
        win_full    = (fill_eff >= FW'(TAPS - 1));
        win_shift   = In_valid && (Control == MODE_WIN);
    end

    always_comb begin
        dot_cnt_next   = dot_cnt_reg;
        fill_next      = fill_reg;
        emit_next      = 1'b0;
        dot_start_next = 1'b0;
        if (In_valid) begin
            dot_cnt_next = cnt_eff;
            fill_next    = fill_eff;
            case (Control)
                MODE_ADD, MODE_MUL: begin
                    emit_next = 1'b1;
                end
                MODE_DOT: begin
                    dot_start_next = (cnt_eff == '0);
                    emit_next      = dot_last;
                    dot_cnt_next   = dot_last ? '0 : cnt_eff + CW'(1);
                end
                default: begin
                    emit_next = win_full;
                    fill_next = win_full ? FW'(TAPS) : fill_eff + FW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mode_q         <= MODE_ADD;
            beat_valid_reg <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            emit0_reg      <= 1'b0;
            dot_start_reg  <= 1'b0;
            dot_cnt_reg    <= '0;
            fill_reg       <= '0;
        end else begin
            beat_valid_reg <= In_valid;
            emit0_reg      <= emit_next;
            dot_start_reg  <= dot_start_next;
            dot_cnt_reg    <= dot_cnt_next;
            fill_reg       <= fill_next;
            if (In_valid) begin
                mode_q <= Control;
                a_reg  <= Input1;
                b_reg  <= Input2;
            end
        end
    end

    // Both lines shift together, so tap k of each always refers to the same beat
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_line
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    sample_line_reg[gi] <= '0;
                    coef_line_reg[gi]   <= '0;
                end else if (win_shift) begin
                    if (gi == 0) begin
                        sample_line_reg[gi] <= Input1;
                        coef_line_reg[gi]   <= Input2;
                    end else begin
                        sample_line_reg[gi] <= sample_line_reg[(gi > 0) ? gi - 1 : 0];
                        coef_line_reg[gi]   <= coef_line_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    win_prod_reg[gi] <= '0;
                end else if (beat_valid_reg && (mode_q == MODE_WIN)) begin
                    win_prod_reg[gi] <= sample_line_reg[gi] * coef_line_reg[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        prod        = a_reg * b_reg;
        dot_acc_sum = (dot_start_reg ? '0 : dot_acc_reg) + OW'(prod);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= MODE_ADD;
            s1_val_reg   <= '0;
            dot_acc_reg  <= '0;
        end else begin
            s1_valid_reg <= beat_valid_reg && emit0_reg;
            if (beat_valid_reg) begin
                s1_mode_reg <= mode_q;
                case (mode_q)
                    MODE_ADD: s1_val_reg <= OW'(a_reg) + OW'(b_reg);
                    MODE_MUL: s1_val_reg <= OW'(prod);
                    MODE_DOT: begin
                        s1_val_reg  <= dot_acc_sum;
                        dot_acc_reg <= emit0_reg ? '0 : dot_acc_sum;
                    end
                    default: s1_val_reg <= s1_val_reg;
                endcase
            end
        end
    end

    // Window reduction sits in the output stage so stage 1 holds only tap products
    always_comb begin
        win_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            win_sum = win_sum + OW'(win_prod_reg[k]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Output1   <= '0;
            Out_valid <= 1'b0;
        end else begin
            Out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                Output1 <= (s1_mode_reg == MODE_WIN) ? win_sum : s1_val_reg;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mode_engine.sv
// Self-checking bench: directed scenarios plus random beats, compared cycle by cycle
// against a queue-based behavioural model of the four modes.
module tb_dsp_mode_engine;
    localparam int DW      = 16;
    localparam int DOT_LEN = 3;
    localparam int TAPS    = 9;
    localparam int GUARD   = 6;
    localparam int OW      = 2*DW + GUARD;

    logic          Clk;
    logic          Reset;
    logic [1:0]    Control;
    logic          In_valid;
    logic [DW-1:0] Input1;
    logic [DW-1:0] Input2;
    logic [OW-1:0] Output1;
    logic          Out_valid;

    dsp_mode_engine #(.DW(DW), .DOT_LEN(DOT_LEN), .TAPS(TAPS), .GUARD(GUARD)) dut (
        .Clk(Clk), .Reset(Reset), .Control(Control), .In_valid(In_valid),
        .Input1(Input1), .Input2(Input2), .Output1(Output1), .Out_valid(Out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            due;
        logic [OW-1:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [1:0]    m_mode;
    logic [OW-1:0] m_acc;
    int            m_cnt;
    int            m_fill;
    logic [DW-1:0] m_s[$];
    logic [DW-1:0] m_c[$];
    logic [OW-1:0] last_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'b00;
        m_acc  = '0;
        m_cnt  = 0;
        m_fill = 0;
        m_s.delete();
        m_c.delete();
        for (int k = 0; k < TAPS; k++) begin
            m_s.push_back('0);
            m_c.push_back('0);
        end
        exp_q.delete();
        last_out = '0;
    endtask

    task automatic model_beat(input logic [1:0] m, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input int edge_n);
        logic [OW-1:0] res;
        logic [DW-1:0] drop;
        bit            emit;
        exp_t          e;
        emit = 0;
        res  = '0;
        if (m != m_mode) begin
            m_acc  = '0;
            m_cnt  = 0;
            m_fill = 0;
        end
        m_mode = m;
        case (m)
            2'b00: begin res = OW'(a) + OW'(b); emit = 1; end
            2'b01: begin res = OW'(a) * OW'(b); emit = 1; end
            2'b10: begin
                m_acc = m_acc + OW'(a) * OW'(b);
                m_cnt++;
                if (m_cnt == DOT_LEN) begin
                    res   = m_acc;
                    emit  = 1;
                    m_acc = '0;
                    m_cnt = 0;
                end
            end
            default: begin
                m_s.push_front(a);
                m_c.push_front(b);
                drop = m_s.pop_back();
                drop = m_c.pop_back();
                if (m_fill < TAPS) m_fill++;
                if (m_fill == TAPS) begin
                    for (int k = 0; k < TAPS; k++) res = res + OW'(m_s[k]) * OW'(m_c[k]);
                    emit = 1;
                end
            end
        endcase
        if (emit) begin
            e.due = edge_n + 2;
            e.val = res;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit v, input logic [1:0] m, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        exp_t e;
        In_valid = v;
        Control  = m;
        Input1   = a;
        Input2   = b;
        if (v) model_beat(m, a, b, cyc + 1);
        @(posedge Clk);
        cyc++;
        #1;
        In_valid = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("out_valid_pulse", 64'(Out_valid), 64'd1);
            check("out_data", 64'(Output1), 64'(e.val));
            last_out = e.val;
            $display("cycle %0d result %h", cyc, Output1);
        end else begin
            check("out_valid_idle", 64'(Out_valid), 64'd0);
            check("out_hold", 64'(Output1), 64'(last_out));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0);
    endtask

    initial begin
        logic [1:0]    rm;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        bit            rv;

        Reset    = 1'b1;
        In_valid = 1'b0;
        Control  = 2'b00;
        Input1   = '0;
        Input2   = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check("reset_output", 64'(Output1), 64'd0);
        check("reset_valid", 64'(Out_valid), 64'd0);
        Reset = 1'b0;

        // ADD carry into bit DW, then hold
        step(1'b1, 2'b00, 16'hFFFF, 16'h0001);
        idle(2);
        check("add_carry", 64'(Output1), 64'h10000);
        idle(5);
        check("add_hold", 64'(Output1), 64'h10000);

        // MUL full range, then back-to-back ADD/MUL
        step(1'b1, 2'b01, 16'hFFFF, 16'hFFFF);
        idle(2);
        check("mul_max", 64'(Output1), 64'hFFFE0001);
        step(1'b1, 2'b00, 16'd3, 16'd4);
        step(1'b1, 2'b01, 16'd3, 16'd4);
        step(1'b0, 2'b00, '0, '0);
        check("b2b_add", 64'(Output1), 64'd7);
        step(1'b0, 2'b00, '0, '0);
        check("b2b_mul", 64'(Output1), 64'd12);

        // DOT with an In_valid gap, then max-value triple
        step(1'b1, 2'b10, 16'd1, 16'd2);
        idle(2);
        step(1'b1, 2'b10, 16'd3, 16'd4);
        step(1'b1, 2'b10, 16'd5, 16'd6);
        idle(2);
        check("dot_gap", 64'(Output1), 64'd44);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 16'hFFFF, 16'hFFFF);
        idle(2);
        check("dot_max", 64'(Output1), 64'h2FFFA0003);

        // WIN fill and streaming
        for (int i = 1; i <= 11; i++) step(1'b1, 2'b11, 16'(i), 16'd1);
        idle(2);
        check("win_stream", 64'(Output1), 64'd63);

        // Mode switch discards a partial dot product
        step(1'b1, 2'b10, 16'd1, 16'd1);
        step(1'b1, 2'b10, 16'd1, 16'd1);
        step(1'b1, 2'b00, 16'd2, 16'd3);
        step(1'b1, 2'b10, 16'd1, 16'd1);
        step(1'b1, 2'b10, 16'd2, 16'd2);
        step(1'b1, 2'b10, 16'd3, 16'd3);
        idle(2);
        check("switch_dot", 64'(Output1), 64'd14);

        // Asynchronous reset in the middle of a window fill
        for (int i = 0; i < 6; i++) step(1'b1, 2'b11, 16'd500 + 16'(i), 16'd7);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_out", 64'(Output1), 64'd0);
        check("async_rst_valid", 64'(Out_valid), 64'd0);
        model_reset();
        @(posedge Clk);
        cyc++;
        #1;
        Reset = 1'b0;
        for (int i = 0; i < TAPS; i++) step(1'b1, 2'b11, 16'd20 + 16'(i), 16'd1);
        idle(2);
        check("win_after_rst", 64'(Output1), 64'd216);

        // Random beats with mostly sticky modes so DOT/WIN groups complete
        rm = 2'b00;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) rm = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(rv, rm, ra, rb);
        end
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mode_engine.md
# dsp_mode_engine

Parametrised four-mode arithmetic engine. It is the next generation of the lab datapath: data width, dot-product length, window length and output guard bits are generics, and it adds an input valid qualifier, an output valid strobe and a uniform pipeline latency. It sits between the stimulus/data source and the result sink. Each accepted operand pair is added, multiplied, accumulated into a dot product, or pushed through a sliding-window correlator, depending on `Control`.

## Interface
- `DW`, 16, operand width, unsigned.
- `DOT_LEN`, 3, pairs per dot product (≥2).
- `TAPS`, 9, sliding-window length for mode 11 (≥2).
- `GUARD`, 6, guard bits above the 2·DW product. `OW = 2*DW+GUARD` (default 38).
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Control`  in  2  mode: 00 ADD, 01 MUL, 10 DOT, 11 WIN. Sampled with each accepted beat.
- `In_valid`  in  1  beat qualifier. `Input1`/`Input2`/`Control` are accepted on a rising edge where it is high.
- `Input1`  in  DW  operand A / sample.
- `Input2`  in  DW  operand B / coefficient.
- `Output1`  out  OW  result, zero-extended. Holds its value until the next result.
- `Out_valid`  out  1  one-cycle pulse when `Output1` updates.

## Operation
- No backpressure: every `In_valid` beat is accepted.
- ADD: result = Input1+Input2 (DW+1 bits), zero-extended to OW.
- MUL: result = Input1·Input2 (2·DW bits), zero-extended.
- DOT:
  - Each beat adds Input1·Input2 to an accumulator and increments a count.
  - On the DOT_LEN-th beat, result = accumulator including that beat. Accumulator and count then clear.
  - Intermediate beats produce no result.
  - `In_valid` gaps inside a dot product are allowed and do not reset it.
- WIN:
  - Each beat shifts Input1 into a TAPS-deep sample line and Input2 into a TAPS-deep coefficient line.
  - A fill counter saturates at TAPS.
  - Once the fill count reaches TAPS (including the current beat), every beat emits result = Σ_{k=0..TAPS-1} s[k]·c[k] over the window after the shift.
- Mode tracking: the last accepted mode is stored in `mode_q`.
  - An accepted beat whose mode differs from `mode_q` first clears the DOT accumulator/count and the WIN fill counter, then processes normally. Partial work is discarded with no output.
  - WIN line contents need not be cleared; the fill counter gates output.
- Width: all arithmetic is modulo 2^OW. With GUARD ≥ ceil(log2(max(DOT_LEN,TAPS))) there is no overflow; otherwise the result wraps silently.
- Reset clears all registers:
  - `Output1`=0, `Out_valid`=0, accumulator/count/fill=0, sample/coefficient lines=0, `mode_q`=00.
  - Reset mid-DOT or mid-WIN discards all partial state.

## Timing
- Uniform latency of 2 edges for all modes:
  - Beat accepted on edge n.
  - Stage-1 register (products / sums / window products) on edge n+1.
  - `Output1` and `Out_valid` on edge n+2.
- Because latency is uniform, results from back-to-back beats of different modes never collide. At most one result is produced per edge.
- `Out_valid` is high for exactly one cycle per result. Consecutive results give consecutive pulses.
- DOT: the result appears 2 edges after the DOT_LEN-th beat.
- WIN: the first result appears 2 edges after the TAPS-th beat since mode entry or reset. After that, results follow each beat with throughput 1/cycle.
- Reset asserts asynchronously; in-flight pipeline contents are dropped. The first beat can be accepted on the first rising edge after deassertion.

## Test plan
- ADD 0xFFFF+0x0001, single beat → 2 edges later `Output1`=0x10000 and `Out_valid` pulses once. Output holds 0x10000 over 5 idle cycles.
- MUL 0xFFFF·0xFFFF → `Output1`=0xFFFE0001 after 2 edges. Back-to-back ADD(3,4) then MUL(3,4) → consecutive results 7 then 12.
- DOT pairs (1,2),(3,4),(5,6) with a 2-cycle `In_valid` gap after the first pair → a single result of 44, exactly one `Out_valid` pulse. A second triple of all (0xFFFF,0xFFFF) → 0x2FFFA0003.
- WIN: Input1=1..9, Input2=1 → no output for beats 1–8; beat 9 → 45; beat 10 (Input1=10) → 54; beat 11 (Input1=11) → 63 on consecutive edges.
- Mode switch: DOT beats (1,1),(1,1) then ADD(2,3) then DOT (1,1),(2,2),(3,3) → outputs are 5, then 14. The partial dot product is discarded.
- Reset mid-WIN after 6 beats → `Output1`=0 and `Out_valid`=0 immediately (asynchronous). After release, 9 new beats are needed before the first result, and the value is unaffected by pre-reset samples.
